// File: rtl/ps_irq_ctrl_if.sv
// ps_irq_ctrl_if: bundle between the program sequencer and its interrupt responder.
// master = sequencer/core side (drives requests, register writes, handshake acks).
// slave  = interrupt controller (drives the vector request, wake and readbacks).
interface ps_irq_ctrl_if #(
    parameter int PMA_SIZE = 16,
    parameter int NUM_IRQ  = 4
);
    logic [NUM_IRQ-1:0]  irq_src;
    logic                ic_gie;
    logic                ic_wr_en;
    logic                ic_wr_sel;
    logic [NUM_IRQ-1:0]  ic_wr_data;
    logic                ps_idle;
    logic                ps_pcstk_full;
    logic                ps_vec_ack;
    logic                ps_rti;
    logic                ic_vec_req;
    logic [PMA_SIZE-1:0] ic_vec_addr;
    logic                ic_wake;
    logic                ic_in_service;
    logic [NUM_IRQ-1:0]  ic_imask;
    logic [NUM_IRQ-1:0]  ic_irptl;
    logic [NUM_IRQ-1:0]  ic_imaskp;
    modport master (
        output irq_src, ic_gie, ic_wr_en, ic_wr_sel, ic_wr_data,
               ps_idle, ps_pcstk_full, ps_vec_ack, ps_rti,
        input  ic_vec_req, ic_vec_addr, ic_wake, ic_in_service,
               ic_imask, ic_irptl, ic_imaskp
    );
    modport slave (
        input  irq_src, ic_gie, ic_wr_en, ic_wr_sel, ic_wr_data,
               ps_idle, ps_pcstk_full, ps_vec_ack, ps_rti,
        output ic_vec_req, ic_vec_addr, ic_wake, ic_in_service,
               ic_imask, ic_irptl, ic_imaskp
    );
endinterface

// File: rtl/ps_irq_ctrl.sv
// ps_irq_ctrl: sequencer interrupt responder (edge latch, mask, priority, vector req/ack, no nesting).
// Ports: clk (rising edge), reset (async active-low), bus (ps_irq_ctrl_if.slave):
//   in : irq_src, ic_gie, ic_wr_en/sel/data, ps_idle, ps_pcstk_full, ps_vec_ack, ps_rti
//   out: ic_vec_req, ic_vec_addr, ic_wake, ic_in_service, ic_imask, ic_irptl, ic_imaskp
module ps_irq_ctrl #(
    parameter int                  PMA_SIZE   = 16,
    parameter int                  NUM_IRQ    = 4,
    parameter logic [PMA_SIZE-1:0] IVT_BASE   = 'h0010,
    parameter int                  IVT_STRIDE = 4
) (
    input logic           clk,
    input logic           reset,
    ps_irq_ctrl_if.slave  bus
);
    localparam int SW = NUM_IRQ > 1 ? $clog2(NUM_IRQ) : 1;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_SVC  = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [NUM_IRQ-1:0]  src_q, imask_q, imask_d, irptl_q, irptl_d, imaskp_q, imaskp_d;
    logic [NUM_IRQ-1:0]  rise, pend, ack_clr;
    logic [SW-1:0]       sel_q, sel_d, sel;
    logic [PMA_SIZE-1:0] addr_q, addr_d;
    logic                ack, withdraw;

    assign rise     = bus.irq_src & ~src_q;
    assign pend     = irptl_q & imask_q;
    assign ack      = state_q == S_REQ && bus.ps_vec_ack;
    assign ack_clr  = ack ? NUM_IRQ'(1) << sel_q : '0;
    // The request is pulled back if its source is no longer pending/enabled or vectoring became unsafe.
    assign withdraw = !irptl_q[sel_q] || !imask_q[sel_q] || !bus.ic_gie || bus.ps_pcstk_full;

    // Lowest set index wins: scan from the top so the last hit is the highest priority.
    always_comb begin
        sel = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (pend[i]) sel = SW'(i);
    end

    always_comb begin
        // OR of the edge comes last so a hardware edge beats both SW write and ack-clear.
        irptl_d  = ((bus.ic_wr_en && bus.ic_wr_sel) ? bus.ic_wr_data : irptl_q) & ~ack_clr | rise;
        imask_d  = (bus.ic_wr_en && !bus.ic_wr_sel) ? bus.ic_wr_data : imask_q;
        state_d  = state_q;
        sel_d    = sel_q;
        addr_d   = addr_q;
        imaskp_d = imaskp_q;
        if (state_q == S_IDLE && |pend && bus.ic_gie && !bus.ps_pcstk_full) begin
            state_d = S_REQ;
            sel_d   = sel;
            addr_d  = IVT_BASE + PMA_SIZE'(sel) * PMA_SIZE'(IVT_STRIDE);
        end else if (ack) begin
            state_d  = S_SVC;
            imaskp_d = imaskp_q | ack_clr;
        end else if (state_q == S_REQ && withdraw) begin
            state_d = S_IDLE;
        end else if (state_q == S_SVC && bus.ps_rti) begin
            state_d  = S_IDLE;
            imaskp_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            src_q    <= '0;
            imask_q  <= '0;
            irptl_q  <= '0;
            imaskp_q <= '0;
            sel_q    <= '0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            src_q    <= bus.irq_src;
            imask_q  <= imask_d;
            irptl_q  <= irptl_d;
            imaskp_q <= imaskp_d;
            sel_q    <= sel_d;
            addr_q   <= addr_d;
        end
    end

    assign bus.ic_vec_req    = state_q == S_REQ;
    assign bus.ic_vec_addr   = addr_q;
    assign bus.ic_wake       = bus.ps_idle & |pend;
    assign bus.ic_in_service = |imaskp_q;
    assign bus.ic_imask      = imask_q;
    assign bus.ic_irptl      = irptl_q;
    assign bus.ic_imaskp     = imaskp_q;
endmodule

// File: tb/tb_ps_irq_ctrl.sv
// tb_ps_irq_ctrl: directed scenarios plus random traffic against a behavioural model of ps_irq_ctrl.
module tb_ps_irq_ctrl;
    logic clk = 0;
    logic reset = 0;
    int   checks = 0;
    int   failures = 0;
    bit   en = 0;

    ps_irq_ctrl_if #(.PMA_SIZE(16), .NUM_IRQ(4)) bus ();

    ps_irq_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // Model: registers as plain bit vectors; m_src = source currently being requested, -1 if none.
    // An ISR is running exactly when m_imaskp is nonzero.
    logic [3:0] m_irptl = 0, m_imask = 0, m_imaskp = 0, m_prev = 0;
    int         m_src = -1;
    logic [3:0] r_rise, r_pend, r_np;
    bit         r_ack;
    int         r_nsrc;

    function automatic int lowest(logic [3:0] v);
        for (int i = 0; i < 4; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_irptl = 0; m_imask = 0; m_imaskp = 0; m_prev = 0; m_src = -1;
        end else begin
            r_rise = bus.irq_src & ~m_prev;
            m_prev = bus.irq_src;
            r_pend = m_irptl & m_imask;
            r_ack  = m_src >= 0 && bus.ps_vec_ack;
            r_nsrc = m_src;
            if (m_src >= 0) begin
                if (r_ack || !(m_irptl[m_src] && m_imask[m_src] && bus.ic_gie && !bus.ps_pcstk_full))
                    r_nsrc = -1;
            end else if (m_imaskp == 0 && r_pend != 0 && bus.ic_gie && !bus.ps_pcstk_full) begin
                r_nsrc = lowest(r_pend);
            end
            r_np = (bus.ic_wr_en && bus.ic_wr_sel) ? bus.ic_wr_data : m_irptl;
            if (r_ack) r_np[m_src] = 1'b0;
            m_irptl = r_np | r_rise;
            if (bus.ic_wr_en && !bus.ic_wr_sel) m_imask = bus.ic_wr_data;
            if (r_ack) m_imaskp[m_src] = 1'b1;
            else if (m_imaskp != 0 && bus.ps_rti) m_imaskp = 0;
            m_src = r_nsrc;
        end
    end

    task automatic chk(string n, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (en) begin
            chk("m_vec_req", 16'(bus.ic_vec_req), 16'(m_src >= 0));
            if (m_src >= 0) chk("m_vec_addr", bus.ic_vec_addr, 16'h0010 + 16'(4 * m_src));
            chk("m_wake", 16'(bus.ic_wake), 16'(bus.ps_idle && |(m_irptl & m_imask)));
            chk("m_in_service", 16'(bus.ic_in_service), 16'(m_imaskp != 0));
            chk("m_imask", 16'(bus.ic_imask), 16'(m_imask));
            chk("m_irptl", 16'(bus.ic_irptl), 16'(m_irptl));
            chk("m_imaskp", 16'(bus.ic_imaskp), 16'(m_imaskp));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(logic s, logic [3:0] d);
        bus.ic_wr_en = 1; bus.ic_wr_sel = s; bus.ic_wr_data = d;
        tick();
        bus.ic_wr_en = 0;
    endtask

    task automatic pulse_ack();
        bus.ps_vec_ack = 1; tick(); bus.ps_vec_ack = 0;
    endtask

    task automatic pulse_rti();
        bus.ps_rti = 1; tick(); bus.ps_rti = 0;
    endtask

    task automatic pulse_src(logic [3:0] v);
        bus.irq_src = v; tick(); bus.irq_src = 0;
    endtask

    logic [3:0] flip;

    initial begin
        bus.irq_src = 0; bus.ic_gie = 0; bus.ic_wr_en = 0; bus.ic_wr_sel = 0; bus.ic_wr_data = 0;
        bus.ps_idle = 0; bus.ps_pcstk_full = 0; bus.ps_vec_ack = 0; bus.ps_rti = 0;
        repeat (3) tick();
        en = 1;
        chk("rst_req", 16'(bus.ic_vec_req), 16'h0);
        chk("rst_addr", bus.ic_vec_addr, 16'h0);
        chk("rst_irptl", 16'(bus.ic_irptl), 16'h0);
        reset = 1;
        tick();
        // 1: single source through the full handshake
        bus.ic_gie = 1;
        wr(0, 4'b0001);
        pulse_src(4'b0001);
        chk("t1_irptl", 16'(bus.ic_irptl), 16'h1);
        tick();
        chk("t1_req", 16'(bus.ic_vec_req), 16'h1);
        chk("t1_addr", bus.ic_vec_addr, 16'h0010);
        pulse_ack();
        chk("t1_irptl_clr", 16'(bus.ic_irptl), 16'h0);
        chk("t1_imaskp", 16'(bus.ic_imaskp), 16'h1);
        chk("t1_req_low", 16'(bus.ic_vec_req), 16'h0);
        pulse_rti();
        chk("t1_imaskp_clr", 16'(bus.ic_imaskp), 16'h0);
        // 2: priority between simultaneous sources
        wr(0, 4'b1111);
        pulse_src(4'b1010);
        tick();
        chk("t2_addr1", bus.ic_vec_addr, 16'h0014);
        pulse_ack();
        pulse_rti();
        tick();
        chk("t2_req3", 16'(bus.ic_vec_req), 16'h1);
        chk("t2_addr3", bus.ic_vec_addr, 16'h001C);
        pulse_ack();
        pulse_rti();
        // 3: full PC stack holds off vectoring
        wr(0, 4'b0001);
        bus.ps_pcstk_full = 1;
        pulse_src(4'b0001);
        repeat (20) tick();
        chk("t3_held", 16'(bus.ic_vec_req), 16'h0);
        bus.ps_pcstk_full = 0;
        tick();
        chk("t3_req", 16'(bus.ic_vec_req), 16'h1);
        pulse_ack();
        pulse_rti();
        // 4: no nesting while in service
        wr(0, 4'b0101);
        pulse_src(4'b0001);
        tick();
        pulse_ack();
        pulse_src(4'b0100);
        repeat (4) tick();
        chk("t4_irptl", 16'(bus.ic_irptl), 16'h4);
        chk("t4_no_req", 16'(bus.ic_vec_req), 16'h0);
        pulse_rti();
        tick();
        chk("t4_req", 16'(bus.ic_vec_req), 16'h1);
        chk("t4_addr", bus.ic_vec_addr, 16'h0018);
        pulse_ack();
        pulse_rti();
        // 5: wake ignores global enable
        bus.ic_gie = 0; bus.ps_idle = 1;
        wr(0, 4'b0001);
        pulse_src(4'b0001);
        tick();
        chk("t5_wake", 16'(bus.ic_wake), 16'h1);
        chk("t5_no_req", 16'(bus.ic_vec_req), 16'h0);
        wr(0, 4'b0000);
        chk("t5_wake_off", 16'(bus.ic_wake), 16'h0);
        wr(1, 4'b0000);
        bus.ic_gie = 1; bus.ps_idle = 0;
        // 6: withdrawal, edge beats SW clear, reset in service
        wr(0, 4'b0001);
        pulse_src(4'b0001);
        tick();
        chk("t6_req", 16'(bus.ic_vec_req), 16'h1);
        wr(1, 4'b0000);
        tick();
        chk("t6_withdrawn", 16'(bus.ic_vec_req), 16'h0);
        bus.ic_wr_en = 1; bus.ic_wr_sel = 1; bus.ic_wr_data = 0; bus.irq_src = 4'b0001;
        tick();
        bus.ic_wr_en = 0; bus.irq_src = 0;
        chk("t6_edge_wins", 16'(bus.ic_irptl), 16'h1);
        tick();
        pulse_ack();
        chk("t6_in_svc", 16'(bus.ic_in_service), 16'h1);
        reset = 0;
        #1;
        chk("t6_rst_svc", 16'(bus.ic_in_service), 16'h0);
        chk("t6_rst_req", 16'(bus.ic_vec_req), 16'h0);
        chk("t6_rst_all", 16'({bus.ic_imask, bus.ic_irptl, bus.ic_imaskp}), 16'h0);
        tick();
        reset = 1;
        // random traffic, checked every cycle by the model compare process
        for (int n = 0; n < 3000; n++) begin
            flip = 4'($urandom) & 4'($urandom) & 4'($urandom);
            bus.irq_src       = bus.irq_src ^ flip;
            bus.ic_gie        = $urandom_range(0, 9) != 0;
            bus.ps_pcstk_full = $urandom_range(0, 7) == 0;
            bus.ps_idle       = 1'($urandom_range(0, 1));
            bus.ic_wr_en      = $urandom_range(0, 9) == 0;
            bus.ic_wr_sel     = 1'($urandom_range(0, 1));
            bus.ic_wr_data    = 4'($urandom);
            bus.ps_vec_ack    = bus.ic_vec_req ? $urandom_range(0, 2) == 0 : $urandom_range(0, 19) == 0;
            bus.ps_rti        = $urandom_range(0, 7) == 0;
            reset             = $urandom_range(0, 599) != 0;
            tick();
        end
        reset = 1; bus.ic_wr_en = 0; bus.ps_vec_ack = 0; bus.ps_rti = 0;
        tick();
        en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
